// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: start/ready/done handshake, operands and result flags
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SIGNED;
  logic             ready;
  logic             done;
  logic             GT;
  logic             LT;
  logic             EQ;
  modport master (output start, A, B, SIGNED, input ready, done, GT, LT, EQ);
  modport slave  (input start, A, B, SIGNED, output ready, done, GT, LT, EQ);
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: chunked MSB-first magnitude compare with early exit
module seq_magnitude_comparator #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  seq_magnitude_comparator_if.slave cmp_if
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic {IDLE, CMP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CHUNK-1:0] ca, cb, flip;
  logic             last;
  // Two's complement ordering falls out of flipping only the overall sign bit.
  assign flip = (sgn_q && idx_q == IW'(N - 1)) ? MSB : '0;
  assign ca   = CHUNK'(a_q >> (CHUNK * idx_q)) ^ flip;
  assign cb   = CHUNK'(b_q >> (CHUNK * idx_q)) ^ flip;
  assign last = ca != cb || idx_q == '0;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    if (state_q == IDLE) begin
      if (cmp_if.start) begin
        a_d     = cmp_if.A;
        b_d     = cmp_if.B;
        sgn_d   = cmp_if.SIGNED & SIGNED_EN;
        idx_d   = IW'(N - 1);
        state_d = CMP;
      end
    end else if (last) begin
      done_d  = 1'b1;
      gt_d    = ca > cb;
      lt_d    = ca < cb;
      eq_d    = ca == cb;
      state_d = IDLE;
    end else begin
      idx_d = idx_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end
  assign cmp_if.ready = state_q == IDLE;
  assign cmp_if.done  = done_q;
  assign cmp_if.GT    = gt_q;
  assign cmp_if.LT    = lt_q;
  assign cmp_if.EQ    = eq_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: four configurations against an arithmetic reference model
module tb_seq_magnitude_comparator;
  localparam int W  = 16;
  localparam int NI = 4;
  localparam int CH [NI] = '{4, 4, 16, 1};
  localparam bit SE [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          sg = 1'b0;
  logic [NI-1:0] rdy, dn, gt, lt, eq;
  bit            busy [NI];
  int            remain [NI];
  bit            mdone [NI];
  logic [2:0]    mflag [NI];
  logic [2:0]    pend [NI];
  int            lat_obs [NI];
  int            checks = 0;
  int            fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : u
    seq_magnitude_comparator_if #(.WIDTH(W)) bus ();
    assign bus.start  = start;
    assign bus.A      = a;
    assign bus.B      = b;
    assign bus.SIGNED = sg;
    seq_magnitude_comparator #(.WIDTH(W), .CHUNK(CH[g]), .SIGNED_EN(SE[g])) dut (
      .clk(clk), .rst_n(rst_n), .cmp_if(bus));
    assign rdy[g] = bus.ready;
    assign dn[g]  = bus.done;
    assign gt[g]  = bus.GT;
    assign lt[g]  = bus.LT;
    assign eq[g]  = bus.EQ;
  end
  function automatic logic [2:0] ref_result(logic [W-1:0] x, logic [W-1:0] y, bit s);
    int xi, yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return xi > yi ? 3'b100 : xi < yi ? 3'b010 : 3'b001;
  endfunction
  function automatic int ref_lat(logic [W-1:0] x, logic [W-1:0] y, int c);
    int n = W / c;
    int mask = (1 << c) - 1;
    for (int j = n - 1; j >= 0; j--)
      if ((int'(x >> (j * c)) & mask) != (int'(y >> (j * c)) & mask)) return n - j;
    return n;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      busy[i] = 0;
      mdone[i] = 0;
      mflag[i] = 3'b000;
    end
  endtask
  task automatic advance();
    for (int i = 0; i < NI; i++) begin
      mdone[i] = 0;
      if (busy[i]) begin
        remain[i]--;
        if (remain[i] == 0) begin
          busy[i] = 0;
          mdone[i] = 1;
          mflag[i] = pend[i];
        end
      end else if (start) begin
        busy[i] = 1;
        remain[i] = ref_lat(a, b, CH[i]);
        pend[i] = ref_result(a, b, sg && SE[i]);
      end
    end
  endtask
  task automatic cycle();
    advance();
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("dut%0d rdy/done/gt/lt/eq", i), {rdy[i], dn[i], gt[i], lt[i], eq[i]},
            {!busy[i], mdone[i], mflag[i]});
  endtask
  task automatic drain(int n);
    start = 1'b0;
    repeat (n) cycle();
  endtask
  task automatic run(logic [W-1:0] x, logic [W-1:0] y, logic s);
    start = 1'b1;
    a = x;
    b = y;
    sg = s;
    cycle();
    start = 1'b0;
    for (int i = 0; i < NI; i++) lat_obs[i] = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      for (int i = 0; i < NI; i++) if (dn[i] && lat_obs[i] == 0) lat_obs[i] = k;
    end
    for (int i = 0; i < NI; i++)
      if (lat_obs[i] == 0) check($sformatf("dut%0d done timeout", i), 0, 1);
  endtask
  task automatic check_reset_outputs(string name);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s dut%0d", name, i), {rdy[i], dn[i], gt[i], lt[i], eq[i]}, 5'b10000);
  endtask
  initial begin
    int ndone;
    int ncyc;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset state");
    rst_n = 1'b1;
    run(16'h1234, 16'h1234, 1'b0);
    check("equal latency", lat_obs[0], 4);
    check("equal flags", {gt[0], lt[0], eq[0]}, 3'b001);
    check("equal chunk16 latency", lat_obs[2], 1);
    run(16'h8000, 16'h7FFF, 1'b0);
    check("early unsigned latency", lat_obs[0], 1);
    check("early unsigned flags", {gt[0], lt[0], eq[0]}, 3'b100);
    run(16'h8000, 16'h7FFF, 1'b1);
    check("early signed flags", {gt[0], lt[0], eq[0]}, 3'b010);
    check("signed_en=0 flags", {gt[1], lt[1], eq[1]}, 3'b100);
    run(16'h1235, 16'h1234, 1'b0);
    check("late diff latency", lat_obs[0], 4);
    check("late diff flags", {gt[0], lt[0], eq[0]}, 3'b100);
    run(16'hFFFF, 16'h0001, 1'b1);
    check("-1 vs 1 latency", lat_obs[0], 1);
    check("-1 vs 1 flags", {gt[0], lt[0], eq[0]}, 3'b010);
    check("-1 vs 1 chunk16 flags", {gt[2], lt[2], eq[2]}, 3'b010);
    run(16'h0001, 16'h0000, 1'b0);
    check("chunk1 latency", lat_obs[3], 16);
    check("chunk1 flags", {gt[3], lt[3], eq[3]}, 3'b100);
    check("chunk16 latency", lat_obs[2], 1);
    start = 1'b1;
    a = 16'h1234;
    b = 16'h1234;
    sg = 1'b0;
    cycle();
    a = 16'h0000;
    b = 16'hFFFF;
    repeat (3) cycle();
    check("busy start ignored", rdy[0], 0);
    cycle();
    check("first result done", dn[0], 1);
    check("first result flags", {gt[0], lt[0], eq[0]}, 3'b001);
    cycle();
    check("back-to-back accepted", {rdy[0], dn[0]}, 2'b00);
    check("flags held", {gt[0], lt[0], eq[0]}, 3'b001);
    start = 1'b0;
    cycle();
    check("second result", {dn[0], gt[0], lt[0], eq[0]}, 4'b1010);
    drain(40);
    start = 1'b1;
    a = 16'h1234;
    b = 16'h1234;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset held");
    rst_n = 1'b1;
    run(16'h1234, 16'h1234, 1'b0);
    check("post-reset latency", lat_obs[0], 4);
    check("post-reset flags", {gt[0], lt[0], eq[0]}, 3'b001);
    ndone = 0;
    ncyc = 0;
    while (ndone < 1000 && ncyc < 30000) begin
      logic [1:0] kind;
      start = $urandom_range(0, 3) != 0;
      a = W'($urandom);
      kind = 2'($urandom_range(0, 3));
      b = kind == 0 ? a : kind == 1 ? a ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
      sg = 1'($urandom_range(0, 1));
      cycle();
      ncyc++;
      if (dn[0]) ndone++;
    end
    check("random sweep completions", ndone, 1000);
    drain(40);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
